pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control unit for the 5-stage core: generates the stall and flush strobes consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Detects load-use hazards, squashes wrong-path instructions on taken branch/jump, and freezes the pipeline while a data-memory access waits on its ready handshake, with a timeout trap. Sits beside the decode stage, fed from ID-stage decode fields, ID/EX register outputs and the MEM-stage memory handshake.

## Interface
- NUM_REGS, 32, architectural register count
- REG_SEL, $clog2(NUM_REGS), register-select width
- WAIT_W, 8, width of memory-wait counter
- MEM_TIMEOUT, 255, wait cycles before trap (must be < 2^WAIT_W)
- PERF_W, 32, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_SEL  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
- ex_rd  in  REG_SEL  destination of instruction in EX (ID/EX rd)
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch or jump
- dmem_req  in  1  MEM stage has an access outstanding
- dmem_ready  in  1  memory completes access this cycle
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold register
- if_id_flush, id_ex_flush  out  1  load NOP into register
- mem_timeout  out  1  sticky trap flag
- state_out  out  2  current FSM state
- stall_cycles, flush_count, load_use_count  out  PERF_W  only with PIPE_CTRL_PERF_EN

## Operation
- FSM states: RUN=2'd0, MEM_WAIT=2'd1, TRAP=2'd2; 2'd3 unused, decodes to TRAP.
- Strobe outputs are combinational from state and inputs; state, counter, mem_timeout are registered.
- Load-use hazard LU = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- RUN priority, highest first:
  - dmem_req && !dmem_ready: all four stalls=1, flushes=0; next state MEM_WAIT, counter<=1.
  - ex_redirect: if_id_flush=1, id_ex_flush=1, all stalls=0 (PC loads target). Redirect overrides LU.
  - LU: pc_stall=1, if_id_stall=1, id_ex_flush=1 (bubble), others 0.
  - else all strobes 0.
- MEM_WAIT:
  - dmem_ready=0: all stalls=1, flushes=0; counter increments; when counter==MEM_TIMEOUT and not ready, next state TRAP.
  - dmem_ready=1: strobes evaluated exactly as RUN with the memory term false (redirect/LU act in the completing cycle); next state RUN, counter<=0.
- TRAP: all stalls=1, flushes=0, mem_timeout=1; exit only via rst_n.
- Stall and flush never both asserted on the same register.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, counter=0, mem_timeout=0, perf counters=0. While rst_n=0 all stalls=0, if_id_flush=1, id_ex_flush=1.
- Hazard and redirect strobes: zero latency (same cycle as inputs).
- LU bubble lasts one cycle; next cycle load is in MEM and LU clears naturally.
- Memory wait of N cycles (ready on Nth cycle after req) stalls N cycles total including the request cycle, ready cycle unstalled.
- Trap asserted on the clock edge after MEM_TIMEOUT not-ready MEM_WAIT cycles; mem_timeout stays 1 until reset.
- Reset mid-MEM_WAIT: immediate return to RUN, counter cleared.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles increments each cycle pc_stall=1; flush_count increments each cycle id_ex_flush=1 due to redirect; load_use_count increments per LU bubble. All saturate at 2^PERF_W-1, clear on reset.
- Undefined: counters and their ports absent; all other behaviour identical.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_stall=1, if_id_stall=1, id_ex_flush=1 that cycle; ex_rd=0 variant -> no strobes.
- Redirect + LU same cycle: ex_redirect=1 with LU true -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> stalls=1 for 3 cycles, state_out=1 then 0, stalls=0 on ready cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready never -> state_out=2, mem_timeout=1 after 4 MEM_WAIT cycles; stays until rst_n=0.
- Async reset mid-wait: drop rst_n between edges in MEM_WAIT -> state_out=0, flushes=1, stalls=0 immediately.
- With PIPE_CTRL_PERF_EN: 2 LU bubbles, 1 redirect, 3-cycle wait -> load_use_count=2, flush_count=1, stall_cycles=5.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush control: load-use bubbles, redirect squash, data-memory wait with timeout trap.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned REG_SEL     = $clog2(NUM_REGS),
  parameter int unsigned WAIT_W      = 8,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned PERF_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_SEL-1:0] id_rs1,
  input  logic [REG_SEL-1:0] id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [REG_SEL-1:0] ex_rd,
  input  logic               ex_mem_read,
  input  logic               ex_redirect,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  output logic               pc_stall,
  output logic               if_id_stall,
  output logic               id_ex_stall,
  output logic               ex_mem_stall,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               mem_timeout,
  output logic [1:0]         state_out
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  stall_cycles,
  output logic [PERF_W-1:0]  flush_count,
  output logic [PERF_W-1:0]  load_use_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TRAP     = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                mem_hold;
  logic                load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Next state; mem_hold marks cycles where the memory handshake freezes everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    mem_hold  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          mem_hold = 1'b1;
          state_d  = ST_MEM_WAIT;
          cnt_d    = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          mem_hold = 1'b1;
          if (cnt_q == TIMEOUT_CNT) begin
            state_d   = ST_TRAP;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        mem_hold  = 1'b1;
        state_d   = ST_TRAP;
        timeout_d = 1'b1;
      end
    endcase
  end

  // Strobes are zero-latency; reset forces both flushes so the pipe fills with NOPs.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_hold) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign state_out   = 2'(state_q);
  assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q, lu_cnt_q;
  logic              redirect_evt, lu_evt;

  assign redirect_evt = rst_n && !mem_hold && ex_redirect;
  assign lu_evt       = rst_n && !mem_hold && !ex_redirect && load_use;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (redirect_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      if (lu_evt && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign flush_count    = flush_cnt_q;
  assign load_use_count = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan cases plus randomized traffic
// compared each cycle against a behavioural model (perf counters checked when PIPE_CTRL_PERF_EN).
module tb_pipe_hazard_ctrl;
  localparam int unsigned REG_SEL     = 5;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned PERF_W      = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_SEL-1:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, dmem_req, dmem_ready;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush;
  logic mem_timeout;
  logic [1:0] state_out;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cycles, flush_count, load_use_count;
`endif

  pipe_hazard_ctrl #(
    .NUM_REGS(32), .REG_SEL(REG_SEL), .WAIT_W(8), .MEM_TIMEOUT(MEM_TIMEOUT), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout(mem_timeout), .state_out(state_out)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .load_use_count(load_use_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: consecutive stalled cycles of the current access, sticky trap, event tallies.
  int     m_run  = 0;
  bit     m_trap = 1'b0;
  longint m_stall = 0, m_flush = 0, m_lu = 0;
  localparam longint PERF_MAX = (longint'(1) << PERF_W) - 1;

  function automatic bit model_lu();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit model_busy();
    return (m_run > 0) ? !dmem_ready : (dmem_req && !dmem_ready);
  endfunction

  // {pc, if_id, id_ex, ex_mem stalls, if_id flush, id_ex flush}
  function automatic logic [5:0] model_strobes();
    if (!rst_n) return 6'b0000_11;
    if (m_trap || model_busy()) return 6'b1111_00;
    if (ex_redirect) return 6'b0000_11;
    if (model_lu()) return 6'b1100_01;
    return 6'b0000_00;
  endfunction

  function automatic logic [1:0] model_state();
    if (!rst_n) return 2'd0;
    if (m_trap) return 2'd2;
    return (m_run > 0) ? 2'd1 : 2'd0;
  endfunction

  task automatic check_model();
    logic [5:0] act, exp;
    act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
    exp = model_strobes();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL strobes t=%0t got %b want %b", $time, act, exp);
    end
    if (state_out !== model_state()) begin
      n_err++;
      $display("FAIL state_out t=%0t got %0d want %0d", $time, state_out, model_state());
    end
    if (mem_timeout !== (rst_n && m_trap)) begin
      n_err++;
      $display("FAIL mem_timeout t=%0t got %b want %b", $time, mem_timeout, rst_n && m_trap);
    end
`ifdef PIPE_CTRL_PERF_EN
    if (stall_cycles !== PERF_W'(m_stall) || flush_count !== PERF_W'(m_flush) ||
        load_use_count !== PERF_W'(m_lu)) begin
      n_err++;
      $display("FAIL perf t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time, stall_cycles,
               flush_count, load_use_count, m_stall, m_flush, m_lu);
    end
`endif
  endtask

  task automatic model_advance();
    bit busy;
    if (!rst_n) begin
      m_run = 0; m_trap = 1'b0; m_stall = 0; m_flush = 0; m_lu = 0;
      return;
    end
    busy = model_busy();
    if (model_strobes()[5] && m_stall < PERF_MAX) m_stall++;
    if (!m_trap && !busy && ex_redirect && m_flush < PERF_MAX) m_flush++;
    if (!m_trap && !busy && !ex_redirect && model_lu() && m_lu < PERF_MAX) m_lu++;
    if (!m_trap) begin
      if (busy) begin
        m_run++;
        if (m_run > int'(MEM_TIMEOUT)) m_trap = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One cycle: drive after the edge, check mid-cycle, advance model before the next edge.
  task automatic cyc(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                     input logic redir, input logic req, input logic rdy);
    @(posedge clk);
    #2;
    rst_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = ld; ex_redirect = redir; dmem_req = req; dmem_ready = rdy;
    #5;
    check_model();
    model_advance();
  endtask

  task automatic idle(input logic rn, input logic req, input logic rdy);
    cyc(rn, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, req, rdy);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_strobes();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
  endfunction

  initial begin
    int rdy_pct;
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_mem_read = 0; ex_redirect = 0; dmem_req = 0; dmem_ready = 0;

    idle(1'b0, 1'b0, 1'b0);
    lit("reset_strobes", 32'(dut_strobes()), 32'b0000_11);
    lit("reset_state", 32'(state_out), 32'd0);
    idle(1'b1, 1'b0, 1'b0);

    // Load-use bubble, then rd=x0 which never hazards.
    cyc(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
    lit("lu_bubble", 32'(dut_strobes()), 32'b1100_01);
    cyc(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
    lit("lu_x0", 32'(dut_strobes()), 32'b0000_00);
    cyc(1, 5'd1, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0);
    lit("lu_rs2", 32'(dut_strobes()), 32'b1100_01);
    cyc(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
    lit("redirect_over_lu", 32'(dut_strobes()), 32'b0000_11);

    // Three stalled cycles, unstalled on the ready cycle.
    idle(1, 1, 0);
    lit("wait_req", 32'({dut_strobes(), state_out}), 32'({6'b1111_00, 2'd0}));
    idle(1, 1, 0);
    lit("wait_1", 32'({dut_strobes(), state_out}), 32'({6'b1111_00, 2'd1}));
    idle(1, 1, 0);
    idle(1, 1, 1);
    lit("wait_ready", 32'({dut_strobes(), state_out}), 32'({6'b0000_00, 2'd1}));
    idle(1, 0, 0);
    lit("wait_done", 32'(state_out), 32'd0);

    // Timeout: request cycle plus MEM_TIMEOUT wait cycles, then sticky trap.
    for (int i = 0; i < 5; i++) idle(1, 1, 0);
    lit("pre_trap", 32'({state_out, mem_timeout}), 32'({2'd1, 1'b0}));
    idle(1, 0, 1);
    lit("trap", 32'({dut_strobes(), state_out, mem_timeout}), 32'({6'b1111_00, 2'd2, 1'b1}));
    for (int i = 0; i < 3; i++) idle(1, 0, 1);
    lit("trap_sticky", 32'({state_out, mem_timeout}), 32'({2'd2, 1'b1}));

    // Async reset mid-wait.
    idle(0, 0, 0);
    idle(1, 1, 0);
    idle(1, 1, 0);
    idle(0, 1, 0);
    lit("reset_mid_wait", 32'({dut_strobes(), state_out}), 32'({6'b0000_11, 2'd0}));

`ifdef PIPE_CTRL_PERF_EN
    idle(1, 0, 0);
    cyc(1, 5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
    cyc(1, 5'd0, 5'd4, 0, 1, 5'd4, 1, 0, 0, 0);
    cyc(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
    idle(1, 1, 0); idle(1, 1, 0); idle(1, 1, 0); idle(1, 1, 1);
    idle(1, 0, 0);
    lit("perf_lu", load_use_count, 32'd2);
    lit("perf_flush", flush_count, 32'd1);
    lit("perf_stall", stall_cycles, 32'd5);
`endif

    // Randomized traffic with varying memory latency and occasional async resets.
    rdy_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) rdy_pct = (i / 64) % 3 == 0 ? 20 : ((i / 64) % 3 == 1 ? 50 : 90);
      cyc(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < rdy_pct));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
